// File: rtl/query_patch_loader.sv
// Collects PATCH_SIZE pixels into one packed word and writes it to patch memory, once per patch.
// Optional sticky overrun flag for pixels that arrive while idle: define QUERY_PATCH_LOADER_OVERRUN_EN.
module query_patch_loader #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH:0]              num_patches,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            in_pixel,
    output logic                             in_ready,
    output logic                             csb0,
    output logic                             web0,
    output logic [ADDR_WIDTH-1:0]            addr0,
    output logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0,
    output logic                             busy,
    output logic                             done
`ifdef QUERY_PATCH_LOADER_OVERRUN_EN
    ,
    output logic                             overrun
`endif
);

    localparam int CW = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
    localparam int NW = ADDR_WIDTH + 1;
    localparam int PW = DATA_WIDTH * PATCH_SIZE;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [NW-1:0]         npatch_q;
    logic [ADDR_WIDTH-1:0] addr_cnt_q;
    logic [CW-1:0]         pix_cnt_q;
    logic [PW-1:0]         patch_q, patch_d;
    logic [NW-1:0]         np_clamped;
    logic                  start_acc, accept, last_pix, last_patch;

    assign start_acc  = start && (state_q == IDLE || state_q == DONE);
    assign accept     = in_valid && (state_q == FILL);
    assign last_pix   = (pix_cnt_q == CW'(PATCH_SIZE - 1));
    assign last_patch = ({1'b0, addr_cnt_q} == (npatch_q - NW'(1)));
    assign np_clamped = (num_patches > NW'(DEPTH)) ? NW'(DEPTH) : num_patches;
    assign in_ready   = (state_q == FILL);

    // Patch with the current pixel dropped into its slot; also the source for wpatch0.
    always_comb begin
        patch_d = patch_q;
        for (int i = 0; i < PATCH_SIZE; i++) begin
            if (accept && pix_cnt_q == CW'(i)) begin
                patch_d[i*DATA_WIDTH +: DATA_WIDTH] = in_pixel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = (num_patches == '0) ? DONE : FILL;
            end
            FILL: begin
                if (accept && last_pix) state_d = WRITE;
            end
            WRITE: begin
                state_d = last_patch ? DONE : FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            npatch_q   <= '0;
            addr_cnt_q <= '0;
            pix_cnt_q  <= '0;
            patch_q    <= '0;
            csb0       <= 1'b1;
            web0       <= 1'b1;
            addr0      <= '0;
            wpatch0    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                npatch_q   <= np_clamped;
                addr_cnt_q <= '0;
                pix_cnt_q  <= '0;
                patch_q    <= '0;
            end else begin
                if (accept) begin
                    patch_q   <= patch_d;
                    pix_cnt_q <= last_pix ? '0 : pix_cnt_q + 1'b1;
                end
                if (state_q == WRITE && !last_patch) begin
                    addr_cnt_q <= addr_cnt_q + 1'b1;
                end
            end
            // Memory strobes are registered, so they are set up on the edge entering WRITE.
            csb0 <= (state_d != WRITE);
            web0 <= (state_d != WRITE);
            if (state_d == WRITE) begin
                addr0   <= addr_cnt_q;
                wpatch0 <= patch_d;
            end
            busy <= (state_d == FILL) || (state_d == WRITE);
            // done trails the DONE state by one cycle; an accepted start drops it at once.
            done <= (state_q == DONE) && !start_acc;
        end
    end

`ifdef QUERY_PATCH_LOADER_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (start_acc) begin
            overrun <= 1'b0;
        end else if (in_valid && (state_q == IDLE || state_q == DONE)) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_query_patch_loader.sv
// Self-checking bench for query_patch_loader: random pixel streams compared against a packing model.
// Define QUERY_PATCH_LOADER_OVERRUN_EN to also exercise the overrun flag.
module tb_query_patch_loader;

    localparam int DW    = 11;
    localparam int PS    = 5;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int PW    = DW * PS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   num_patches = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic          in_ready, csb0, web0, busy, done;
    logic [AW-1:0] addr0;
    logic [PW-1:0] wpatch0;
`ifdef QUERY_PATCH_LOADER_OVERRUN_EN
    logic          overrun;
`endif

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wr_addr[$];
    logic [PW-1:0] wr_data[$];
    logic [PW-1:0] exp_data[$];
    logic [DW-1:0] pix[$];
    int r_first, r_done, r_busy, r_rdy_low;

    query_patch_loader #(
        .DATA_WIDTH(DW),
        .PATCH_SIZE(PS),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_patches(num_patches),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .csb0       (csb0),
        .web0       (web0),
        .addr0      (addr0),
        .wpatch0    (wpatch0),
        .busy       (busy),
        .done       (done)
`ifdef QUERY_PATCH_LOADER_OVERRUN_EN
        ,
        .overrun    (overrun)
`endif
    );

    always #5 clk = ~clk;

    // Memory port monitor: every selected cycle is one write.
    always @(negedge clk) begin
        if (rst_n && csb0 === 1'b0) begin
            wr_addr.push_back(addr0);
            wr_data.push_back(wpatch0);
            checks++;
            if (web0 !== 1'b0) begin
                errors++;
                $display("FAIL web0_in_write: got %b want 0", web0);
            end
        end
    end

    // Reference: patch p is pixels p*PS .. p*PS+PS-1, first pixel in the low bits.
    function automatic void build_model(input int num);
        int n;
        logic [PW-1:0] w;
        n = (num > DEPTH) ? DEPTH : num;
        exp_data.delete();
        for (int p = 0; p < n; p++) begin
            w = '0;
            for (int k = 0; k < PS; k++) w = w | (PW'(pix[p*PS+k]) << (k * DW));
            exp_data.push_back(w);
        end
    endfunction

    // mode 0: in_valid held, 1: toggling, 2: random gaps. Cycle 0 is the start cycle.
    task automatic do_load(input int num, input int mode, input bit seq, input int max_cycles);
        int n, npix, idx, cyc;
        n    = (num > DEPTH) ? DEPTH : num;
        npix = n * PS;
        pix.delete();
        for (int i = 0; i < npix; i++) pix.push_back(seq ? DW'(i + 1) : DW'($urandom));
        build_model(num);
        wr_addr.delete();
        wr_data.delete();
        r_first = -1; r_done = -1; r_busy = 0; r_rdy_low = 0;
        @(posedge clk); #1;
        start = 1'b1;
        num_patches = (AW + 1)'(num);
        in_valid = 1'b0;
        idx = 0;
        cyc = 0;
        while (cyc < max_cycles && !(idx >= npix && r_done >= 0)) begin
            if (cyc > 0 && idx < npix) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = ((cyc % 2) == 1);
                    default: in_valid = ($urandom_range(0, 3) != 0);
                endcase
                in_pixel = pix[idx];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (r_first < 0) r_first = cyc;
                idx++;
            end
            if (busy) begin
                r_busy++;
                if (!in_ready) r_rdy_low++;
            end
            if (cyc > 0 && done && r_done < 0) r_done = cyc;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= max_cycles) begin
            checks++;
            errors++;
            $display("FAIL timeout: load of %0d patches not done within %0d cycles", num, max_cycles);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, csb0, web0, busy, done} !== 5'b01100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 01100", {in_ready, csb0, web0, busy, done});
        end
        checks++;
        if (addr0 !== '0 || wpatch0 !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr %0h patch %0h want 0 0", addr0, wpatch0);
        end
`ifdef QUERY_PATCH_LOADER_OVERRUN_EN
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_overrun: got %b want 0", overrun);
        end
`endif
        rst_n = 1'b1;
        // Stray pixels while idle must not start anything.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_pixel = DW'($urandom);
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL idle_stray: got busy %b done %b ready %b writes %0d want 0 0 0 0",
                     busy, done, in_ready, wr_addr.size());
        end
    endtask

    task automatic test_directed();
        do_load(2, 0, 1'b1, 100);
        checks++;
        if (wr_data.size() != 2) begin
            errors++;
            $display("FAIL directed_count: got %0d want 2", wr_data.size());
        end
        for (int i = 0; i < wr_data.size() && i < exp_data.size(); i++) begin
            checks++;
            if (wr_addr[i] !== AW'(i) || wr_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL directed_write%0d: got %0d/%0h want %0d/%0h",
                         i, wr_addr[i], wr_data[i], i, exp_data[i]);
            end
        end
        checks++;
        if (r_done - r_first != 13) begin
            errors++;
            $display("FAIL directed_done_latency: got %0d want 13", r_done - r_first);
        end
        checks++;
        if (r_busy != 12 || r_rdy_low != 2) begin
            errors++;
            $display("FAIL directed_busy: got busy %0d rdy_low %0d want 12 2", r_busy, r_rdy_low);
        end
    endtask

    task automatic test_zero();
        do_load(0, 0, 1'b0, 20);
        checks++;
        if (r_done != 2) begin
            errors++;
            $display("FAIL zero_done_cycle: got %0d want 2", r_done);
        end
        checks++;
        if (r_busy != 0 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL zero_idle: got busy %0d writes %0d want 0 0", r_busy, wr_addr.size());
        end
    endtask

    task automatic test_toggle();
        do_load(1, 1, 1'b0, 100);
        checks++;
        if (wr_data.size() != 1 || (wr_data.size() == 1 && wr_data[0] !== exp_data[0])) begin
            errors++;
            $display("FAIL toggle_write: got %0d writes first %0h want 1 %0h",
                     wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : '0, exp_data[0]);
        end
        checks++;
        if (r_rdy_low != 1 || r_done != 12) begin
            errors++;
            $display("FAIL toggle_ready: got rdy_low %0d done %0d want 1 12", r_rdy_low, r_done);
        end
    endtask

    task automatic test_random();
        int num;
        for (int t = 0; t < 5; t++) begin
            num = $urandom_range(1, 6);
            do_load(num, 2, 1'b0, 400);
            checks++;
            if (wr_data.size() != num) begin
                errors++;
                $display("FAIL random%0d_count: got %0d want %0d", t, wr_data.size(), num);
            end
            for (int i = 0; i < wr_data.size() && i < exp_data.size(); i++) begin
                checks++;
                if (wr_addr[i] !== AW'(i) || wr_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL random%0d_write%0d: got %0d/%0h want %0d/%0h",
                             t, i, wr_addr[i], wr_data[i], i, exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        wr_addr.delete();
        wr_data.delete();
        @(posedge clk); #1;
        start = 1'b1;
        num_patches = (AW + 1)'(1);
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pixel = DW'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, csb0, web0, busy, done} !== 5'b01100 || wpatch0 !== '0) begin
            errors++;
            $display("FAIL midreset_async: got %b patch %0h want 01100 0",
                     {in_ready, csb0, web0, busy, done}, wpatch0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL midreset_nowrite: got %0d writes want 0", wr_addr.size());
        end
        do_load(1, 0, 1'b0, 50);
        checks++;
        if (wr_data.size() != 1 ||
            (wr_data.size() == 1 && (wr_addr[0] !== '0 || wr_data[0] !== exp_data[0]))) begin
            errors++;
            $display("FAIL midreset_reload: got %0d writes first %0h want 1 %0h at 0",
                     wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : '0, exp_data[0]);
        end
    endtask

    task automatic test_clamp();
        int bad;
        do_load(600, 0, 1'b0, 4000);
        bad = 0;
        checks++;
        if (wr_data.size() != DEPTH) begin
            errors++;
            $display("FAIL clamp_count: got %0d want %0d", wr_data.size(), DEPTH);
        end
        for (int i = 0; i < wr_data.size() && i < exp_data.size(); i++) begin
            if (wr_addr[i] !== AW'(i) || wr_data[i] !== exp_data[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clamp_writes: got %0d wrong writes want 0", bad);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL clamp_done: got %b want 1", done);
        end
    endtask

`ifdef QUERY_PATCH_LOADER_OVERRUN_EN
    task automatic test_overrun();
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (overrun !== 1'b1) begin
                errors++;
                $display("FAIL overrun_set%0d: got %b want 1", i, overrun);
            end
        end
        @(posedge clk); #1;
        start = 1'b1;
        num_patches = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_zero();
        test_toggle();
        test_random();
        test_reset_mid();
        test_clamp();
`ifdef QUERY_PATCH_LOADER_OVERRUN_EN
        test_overrun();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/query_patch_loader.md
QUERY_PATCH_LOADER -- requirements
Module: query_patch_loader

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 11, pixel width; PATCH_SIZE, default 5, pixels per patch; ADDR_WIDTH, default 9, patch-memory address width; DEPTH, default 512, patch-memory entries.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load
- num_patches  in  ADDR_WIDTH+1  number of patches to load; sampled on start
- in_valid  in  1  pixel valid
- in_pixel  in  DATA_WIDTH  pixel value
- in_ready  out  1  pixel accepted when in_valid and in_ready are both 1
- csb0  out  1  memory chip select, active-low
- web0  out  1  memory write enable, active-low
- addr0  out  ADDR_WIDTH  memory write address
- wpatch0  out  DATA_WIDTH*PATCH_SIZE  packed patch
- busy  out  1  load in progress
- done  out  1  load complete; held until the next accepted start

Function
REQ-003 SHALL implement states IDLE, FILL, WRITE and DONE.
REQ-004 IDLE/DONE: start=1 SHALL latch num_patches, clear the pixel and address counters, and clear done. The next state SHALL be FILL, or DONE on the following cycle if num_patches=0.
REQ-005 start SHALL be ignored while in FILL or WRITE.
REQ-006 FILL: in_ready=1; each accepted pixel SHALL go to slot k, bits [k*DATA_WIDTH +: DATA_WIDTH], where k is the pixel counter from 0 to PATCH_SIZE-1; the first pixel lands in the LSBs.
REQ-007 FILL: acceptance of the pixel with k=PATCH_SIZE-1 SHALL move the block to WRITE on the next cycle and reset k to 0.
REQ-008 WRITE SHALL last exactly one cycle: csb0=0, web0=0, addr0=address counter, wpatch0=assembled patch, in_ready=0.
REQ-009 Outside WRITE, csb0=1 and web0=1; addr0 and wpatch0 hold their last values.
REQ-010 After WRITE: if the address counter equals latched num_patches-1, go to DONE; otherwise increment the counter and return to FILL.
REQ-011 Throughput SHALL be one patch per PATCH_SIZE+1 cycles when in_valid is held at 1.
REQ-012 in_valid=0 in FILL SHALL stall with no state change; a partial patch is retained.
REQ-013 num_patches greater than DEPTH SHALL be clamped to DEPTH on latch, so the address never wraps.
REQ-014 busy=1 in FILL and WRITE, else 0; done=1 only in DONE.
REQ-015 All outputs SHALL be registered, except in_ready, which is decoded from state.

Reset
REQ-016 rst_n=0 SHALL immediately force: state IDLE, in_ready=0, csb0=1, web0=1, addr0=0, wpatch0=0, busy=0, done=0, all counters 0.
REQ-017 Reset asserted mid-load SHALL abandon the load with no further memory write; the partial patch is discarded.
REQ-018 After rst_n deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-019 With macro QUERY_PATCH_LOADER_OVERRUN_EN defined, the block SHALL add output overrun (1 bit, reset 0). It is set sticky when in_valid=1 while state is IDLE or DONE, and cleared by an accepted start.
REQ-020 Without QUERY_PATCH_LOADER_OVERRUN_EN, the overrun port and its logic SHALL be absent; stray in_valid is silently ignored.

Verification
REQ-021 Reset, then start with num_patches=2, then pixels 1..10 with in_valid held -> writes at addr0=0, wpatch0={5,4,3,2,1}, and addr0=1, wpatch0={10,9,8,7,6}; done=1 at 12+1 cycles after the first accept.
REQ-022 num_patches=0 -> no csb0=0 cycle; done=1 two cycles after start; busy stays 0.
REQ-023 in_valid toggled 1/0 every cycle with num_patches=1 -> one write of the correct packed patch, and in_ready=0 only in WRITE.
REQ-024 rst_n pulsed low after 3 pixels of patch 0 -> csb0 and web0 go to 1 immediately; after a new start with 5 pixels, the write goes to addr0=0 with only the new pixels.
REQ-025 num_patches=600 -> exactly 512 writes to addresses 0..511, then done=1.
REQ-026 With QUERY_PATCH_LOADER_OVERRUN_EN defined, in_valid=1 in DONE -> overrun=1 on the next cycle and still 1 until start; then 0.
